// File: rtl/mant_iter_divider.sv
// mant_iter_divider: iterative unsigned restoring divider for the mantissa
// datapath. One quotient bit is produced per clock by trial subtraction.
// A zero divisor short-circuits to an all-ones quotient one edge after accept.
module mant_iter_divider #(
  parameter int W  = 11,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  // ZDIV is the single cycle between accepting a zero divisor and reporting it;
  // it is neither ready nor busy, so a new request cannot collide with it.
  typedef enum logic [1:0] {IDLE, CALC, ZDIV, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic [W-1:0]   q;
  logic [W-1:0]   dvsr;
  logic [W:0]     r;
  logic [W:0]     trial;
  logic [W:0]     nextR;
  logic [W-1:0]   nextQ;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor if it fits, and record the quotient bit.
  always_comb begin
    trial = {r[W-1:0], q[W-1]};
    nextR = trial;
    nextQ = {q[W-2:0], 1'b0};
    if (trial >= {1'b0, dvsr}) begin
      nextR = trial - {1'b0, dvsr};
      nextQ = {q[W-2:0], 1'b1};
    end
  end

  // Handshake flags are decoded straight from the state register.
  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == CALC);

  // Control FSM plus datapath registers; results and done are loaded
  // together so they are always coherent in the done cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      q           <= '0;
      r           <= '0;
      dvsr        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            q           <= dividend;
            r           <= '0;
            count       <= '0;
            dvsr        <= divisor;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            state       <= (divisor == '0) ? ZDIV : CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          r     <= nextR;
          q     <= nextQ;
          count <= count + 1'b1;
          if (count == CW'(W - 1)) begin
            quotient  <= nextQ;
            remainder <= nextR[W-1:0];
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        ZDIV: begin
          quotient    <= '1;
          remainder   <= q;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mant_iter_divider.sv
// tb_mant_iter_divider: directed scenarios plus a randomized sweep of the
// 11-bit iterative divider, compared against plain integer division.
module tb_mant_iter_divider;

  localparam int W = 11;
  localparam int MAXLAT = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         ready, busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  mant_iter_divider #(.W(W), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .ready(ready), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference model: integer division, with the zero-divisor convention.
  function automatic void refDiv(input int a, input int b, output int eq, output int er,
                                 output int edz, output int elat);
    if (b == 0) begin
      eq = (1 << W) - 1; er = a; edz = 1; elat = 1;
    end else begin
      eq = a / b; er = a % b; edz = 0; elat = W;
    end
  endfunction

  // Drive one request from the current time, scramble operands after the
  // accept edge, and return what the DUT reports at its done pulse.
  task automatic runOp(input int a, input int b, output int lat, output int oq,
                       output int orr, output int odz);
    start = 1'b1; dividend = W'(a); divisor = W'(b);
    @(posedge clk); #1;
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    lat = 0;
    while (!done && lat < MAXLAT) begin
      @(posedge clk); #1;
      lat++;
    end
    oq = int'(quotient); orr = int'(remainder); odz = int'(div_by_zero);
  endtask

  task automatic checkOp(input string name, input int a, input int b);
    int lat, oq, orr, odz, eq, er, edz, elat;
    refDiv(a, b, eq, er, edz, elat);
    runOp(a, b, lat, oq, orr, odz);
    checks += 4;
    if (lat !== elat) begin errors++; $display("[TB] FAIL %s latency got=%0d exp=%0d", name, lat, elat); end
    if (oq !== eq) begin errors++; $display("[TB] FAIL %s quotient got=%0d exp=%0d", name, oq, eq); end
    if (orr !== er) begin errors++; $display("[TB] FAIL %s remainder got=%0d exp=%0d", name, orr, er); end
    if (odz !== edz) begin errors++; $display("[TB] FAIL %s div_by_zero got=%0d exp=%0d", name, odz, edz); end
  endtask

  task automatic test_reset;
    #2;
    checks += 6;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", ready); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    if (quotient !== '0) begin errors++; $display("[TB] FAIL reset_quotient got=%0d exp=0", quotient); end
    if (remainder !== '0) begin errors++; $display("[TB] FAIL reset_remainder got=%0d exp=0", remainder); end
    if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz got=%b exp=0", div_by_zero); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  // 100/7 with handshake visibility: ready drops and busy spans W cycles.
  task automatic test_basic;
    int busyCycles = 0;
    int lat = 0;
    @(negedge clk);
    start = 1'b1; dividend = 11'd100; divisor = 11'd7;
    @(posedge clk); #1;
    start = 1'b0;
    checks += 2;
    if (ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_drop got=%b exp=0", ready); end
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_rise got=%b exp=1", busy); end
    while (!done && lat < MAXLAT) begin
      if (busy) busyCycles++;
      @(posedge clk); #1;
      lat++;
    end
    checks += 5;
    if (busyCycles !== W) begin errors++; $display("[TB] FAIL basic_busy_cycles got=%0d exp=%0d", busyCycles, W); end
    if (lat !== W) begin errors++; $display("[TB] FAIL basic_latency got=%0d exp=%0d", lat, W); end
    if (quotient !== 11'd14) begin errors++; $display("[TB] FAIL basic_quotient got=%0d exp=14", quotient); end
    if (remainder !== 11'd2) begin errors++; $display("[TB] FAIL basic_remainder got=%0d exp=2", remainder); end
    if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL basic_dbz got=%b exp=0", div_by_zero); end
    @(posedge clk); #1;
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got=%b exp=0", done); end
    if (quotient !== 11'd14) begin errors++; $display("[TB] FAIL basic_hold got=%0d exp=14", quotient); end
  endtask

  task automatic test_boundaries;
    @(negedge clk); checkOp("max_by_one", 2047, 1);
    @(negedge clk); checkOp("small_by_large", 3, 10);
    @(negedge clk); checkOp("max_by_max", 2047, 2047);
  endtask

  task automatic test_div_zero;
    @(negedge clk); checkOp("div_zero", 5, 0);
    @(negedge clk); checkOp("after_zero", 9, 3);
    checkOp("zero_b2b_1", 77, 0);
    checkOp("zero_b2b_2", 1234, 0);
  endtask

  // A second start mid-CALC must be ignored and produce no extra done.
  task automatic test_ignore_busy;
    int dones = 0;
    int lat = 0;
    int firstDone = -1;
    @(negedge clk);
    start = 1'b1; dividend = 11'd100; divisor = 11'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 4) begin start = 1'b1; dividend = 11'd50; divisor = 11'd5; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (done) begin
        dones++;
        if (firstDone < 0) begin
          firstDone = lat;
          checks += 2;
          if (quotient !== 11'd14) begin errors++; $display("[TB] FAIL ignore_quotient got=%0d exp=14", quotient); end
          if (remainder !== 11'd2) begin errors++; $display("[TB] FAIL ignore_remainder got=%0d exp=2", remainder); end
        end
      end
    end
    checks += 2;
    if (dones !== 1) begin errors++; $display("[TB] FAIL ignore_done_count got=%0d exp=1", dones); end
    if (firstDone !== W) begin errors++; $display("[TB] FAIL ignore_latency got=%0d exp=%0d", firstDone, W); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    checkOp("b2b_first", 100, 7);
    checkOp("b2b_second", 1000, 33);
  endtask

  // Asynchronous reset mid-CALC abandons the operation without a done.
  task automatic test_reset_mid;
    int dones = 0;
    @(negedge clk);
    start = 1'b1; dividend = 11'd100; divisor = 11'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks += 5;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got=%b exp=1", ready); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done got=%b exp=0", done); end
    if (quotient !== '0) begin errors++; $display("[TB] FAIL midrst_quotient got=%0d exp=0", quotient); end
    if (remainder !== '0) begin errors++; $display("[TB] FAIL midrst_remainder got=%0d exp=0", remainder); end
    @(negedge clk); rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("[TB] FAIL midrst_spurious_done got=%0d exp=0", dones); end
    @(negedge clk); checkOp("midrst_fresh", 100, 7);
  endtask

  // Random operand pairs issued back to back; divisor is biased towards
  // small values and zero so every path is exercised regularly.
  task automatic test_random;
    int a, b;
    for (int i = 0; i < 1500; i++) begin
      a = int'($urandom_range(0, 2047));
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = int'($urandom_range(1, 15));
        default: b = int'($urandom_range(0, 2047));
      endcase
      checkOp("random", a, b);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_boundaries;
    test_div_zero;
    test_ignore_busy;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
